mem_req_arbiter: RTL and testbench

Shares one downstream memory port and one direct address-translation instance between the instruction-fetch and data-access requesters of the CPU core. Picks one requester at a time, translates its virtual address (kseg0/kseg1 folding, uncached classification), and holds the translated request on the downstream port until it completes. Sits between the pipeline's fetch/memory stages and the cache/uncached bus logic.

---
 rtl/mem_req_arbiter_pkg.sv | 16 +
 rtl/mem_req_arbiter_if.sv | 37 +++
 rtl/mem_req_arbiter_trans_direct.sv | 15 +
 rtl/mem_req_arbiter.sv | 76 +++++++
 tb/tb_mem_req_arbiter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg: shared types for the fetch/data memory request arbiter
package mem_req_arbiter_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  strobe_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  typedef enum logic {SRC_I, SRC_D} src_e;
  typedef struct packed {
    addr_t   addr;
    logic    uncached;
    logic    write;
    strobe_t strobe;
    word_t   wdata;
    src_e    src;
  } req_t;
endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: requester and downstream port bundle; slave is the arbiter view
interface mem_req_arbiter_if;
  import mem_req_arbiter_pkg::*;
  logic    i_valid;
  addr_t   i_addr;
  logic    i_done;
  word_t   i_rdata;
  logic    d_valid;
  addr_t   d_addr;
  logic    d_write;
  strobe_t d_strobe;
  word_t   d_wdata;
  logic    d_done;
  word_t   d_rdata;
  logic    out_valid;
  addr_t   out_addr;
  logic    out_uncached;
  logic    out_write;
  strobe_t out_strobe;
  word_t   out_wdata;
  logic    out_src;
  logic    out_ready;
  logic    out_done;
  word_t   out_rdata;
  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_write, d_strobe, d_wdata,
    input  out_ready, out_done, out_rdata,
    output i_done, i_rdata, d_done, d_rdata,
    output out_valid, out_addr, out_uncached, out_write, out_strobe, out_wdata, out_src
  );
  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_write, d_strobe, d_wdata,
    output out_ready, out_done, out_rdata,
    input  i_done, i_rdata, d_done, d_rdata,
    input  out_valid, out_addr, out_uncached, out_write, out_strobe, out_wdata, out_src
  );
endinterface

// File: rtl/mem_req_arbiter_trans_direct.sv
// trans_direct: direct-mapped MIPS address translation (kseg0/kseg1 folding, uncached classify)
module trans_direct
  import mem_req_arbiter_pkg::*;
(
  input  addr_t i_vaddr,
  input  logic  i_k0_uncached,
  output addr_t o_paddr,
  output logic  o_uncached
);
  logic w_kseg01;
  assign w_kseg01   = i_vaddr[31:30] == 2'b10;
  // kseg0/kseg1 both fold onto the low 512 MB, bit 28 selects 0x0 or 0x1
  assign o_paddr    = w_kseg01 ? {3'b000, i_vaddr[28:0]} : i_vaddr;
  assign o_uncached = (i_vaddr[31:29] == 3'b101) || ((i_vaddr[31:29] == 3'b100) && i_k0_uncached);
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: grants fetch or data access to one translated downstream memory port
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               k0_uncached,
  mem_req_arbiter_if.slave   bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_e     r_state, w_next;
  req_t       r_req;
  logic [3:0] r_streak;
  logic       w_any, w_grant, w_grant_d, w_complete, w_uncached, w_i_done, w_d_done;
  addr_t      w_vaddr, w_paddr;
  assign w_any     = bus.i_valid || bus.d_valid;
  assign w_grant   = (r_state == IDLE) && w_any;
  // data has priority until a pending fetch has watched LIMIT data grants in a row
  assign w_grant_d = bus.d_valid && !(bus.i_valid && r_streak == LIMIT);
  assign w_vaddr   = w_grant_d ? bus.d_addr : bus.i_addr;
  trans_direct u_trans (
    .i_vaddr       (w_vaddr),
    .i_k0_uncached (k0_uncached),
    .o_paddr       (w_paddr),
    .o_uncached    (w_uncached)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end
  always_comb begin
    w_next     = r_state;
    w_complete = 1'b0;
    case (r_state)
      IDLE:    w_next = w_any ? ISSUE : IDLE;
      ISSUE: begin
        w_complete = bus.out_ready && bus.out_done;
        w_next     = bus.out_ready ? (bus.out_done ? IDLE : WAIT) : ISSUE;
      end
      WAIT: begin
        w_complete = bus.out_done;
        w_next     = bus.out_done ? IDLE : WAIT;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_req    <= '0;
      r_streak <= '0;
    end else if (w_grant) begin
      r_req    <= '{addr:     w_paddr,
                    uncached: w_uncached,
                    write:    w_grant_d && bus.d_write,
                    strobe:   w_grant_d ? bus.d_strobe : '0,
                    wdata:    w_grant_d ? bus.d_wdata : '0,
                    src:      w_grant_d ? SRC_D : SRC_I};
      r_streak <= (w_grant_d && bus.i_valid) ? ((r_streak == LIMIT) ? r_streak : r_streak + 4'd1) : '0;
    end
  end
  assign w_i_done         = w_complete && (r_req.src == SRC_I);
  assign w_d_done         = w_complete && (r_req.src == SRC_D);
  assign bus.i_done       = w_i_done;
  assign bus.d_done       = w_d_done;
  assign bus.i_rdata      = w_i_done ? bus.out_rdata : '0;
  assign bus.d_rdata      = w_d_done ? bus.out_rdata : '0;
  assign bus.out_valid    = r_state == ISSUE;
  assign bus.out_addr     = r_req.addr;
  assign bus.out_uncached = r_req.uncached;
  assign bus.out_write    = r_req.write;
  assign bus.out_strobe   = r_req.strobe;
  assign bus.out_wdata    = r_req.wdata;
  assign bus.out_src      = r_req.src;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized scoreboard bench for mem_req_arbiter against a behavioural model
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;
  localparam int LIMIT = 4;
  logic clk = 0, resetn = 0, k0 = 0;
  mem_req_arbiter_if bus();
  mem_req_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .resetn(resetn), .k0_uncached(k0), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic unc; logic wr; logic [3:0] st; logic [31:0] wd; logic src; int cyc;} exp_t;
  typedef struct {logic src; logic [31:0] rd;} done_t;
  exp_t  exp_q[$];
  done_t dq[$];
  logic  glog[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic iv = 0, dv = 0, dw = 0;
  logic [31:0] ia = 0, da = 0, dd = 0;
  logic [3:0] ds = 0;
  bit m_idle = 1, inflight = 0, acc = 0, fin = 0, m_src = 0;
  int m_streak = 0;
  exp_t cur;
  bit have = 0, pv = 0, wait_st = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kseg0 (0x8/0x9) and kseg1 (0xA/0xB) map to physical 0x0xxx_xxxx / 0x1xxx_xxxx
  function automatic logic [32:0] xlate(logic [31:0] va, logic k);
    int seg, pseg;
    logic unc;
    seg  = int'(va[31:28]);
    pseg = (seg == 8 || seg == 10) ? 0 : (seg == 9 || seg == 11) ? 1 : seg;
    unc  = (seg == 10 || seg == 11) || ((seg == 8 || seg == 9) && k);
    return {unc, 4'(pseg), va[27:0]};
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 8))
      0: return 32'hA000_1000;
      1: return 32'h9FC0_0000;
      2: return 32'h0040_0010;
      3: return 32'h8000_0180;
      4: return 32'hBFC0_0004;
      5: return 32'hC000_0000;
      6: return 32'h7FFF_FFFC;
      default: return $urandom;
    endcase
  endfunction

  task automatic step(int p_i, int p_d, int p_rdy, int p_done);
    logic g;
    logic [32:0] x;
    @(negedge clk);
    if (fin) begin
      if (m_src) dv = 0; else iv = 0;
      fin = 0; inflight = 0; m_idle = 1;
    end
    if (!iv && $urandom_range(0, 99) < p_i) begin iv = 1; ia = pick_addr(); end
    if (!dv && $urandom_range(0, 99) < p_d) begin
      dv = 1; da = pick_addr(); dw = 1'($urandom); ds = 4'($urandom); dd = $urandom;
    end
    k0 = 1'($urandom);
    bus.i_valid = iv;
    bus.i_addr  = (inflight && !m_src) ? $urandom : ia;
    bus.d_valid = dv;
    if (inflight && m_src) begin
      bus.d_addr = $urandom; bus.d_write = 1'($urandom); bus.d_strobe = 4'($urandom); bus.d_wdata = $urandom;
    end else begin
      bus.d_addr = da; bus.d_write = dw; bus.d_strobe = ds; bus.d_wdata = dd;
    end
    bus.out_ready = bus.out_valid ? 1'b0 : 1'($urandom);
    bus.out_done  = 0;
    bus.out_rdata = $urandom;
    if (bus.out_valid && $urandom_range(0, 99) < p_rdy) begin bus.out_ready = 1; acc = 1; end
    if (acc && $urandom_range(0, 99) < p_done) begin
      bus.out_done = 1;
      dq.push_back('{m_src, bus.out_rdata});
      acc = 0; fin = 1;
    end
    if (m_idle && (iv || dv)) begin
      g = dv && !(iv && m_streak == LIMIT);
      m_streak = (g && iv) ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
      x = xlate(g ? da : ia, k0);
      exp_q.push_back('{x[31:0], x[32], g && dw, g ? ds : 4'h0, g ? dd : 32'h0, g, cyc});
      m_src = g; inflight = 1; m_idle = 0;
    end
  endtask

  task automatic hold_reset(bit done_during);
    @(negedge clk);
    resetn = 0;
    iv = 0; dv = 0; m_idle = 1; inflight = 0; acc = 0; fin = 0; m_streak = 0;
    exp_q.delete(); dq.delete();
    bus.i_valid = 0; bus.d_valid = 0; bus.out_ready = done_during; bus.out_done = done_during;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_done", {bus.i_done, bus.d_done}, 0);
    @(negedge clk);
    bus.out_ready = 0; bus.out_done = 0;
    resetn = 1;
  endtask

  initial begin
    forever begin
      @(negedge clk); #2;
      if (!resetn) begin have = 0; pv = 0; wait_st = 0; continue; end
      if (bus.out_valid && !pv) begin
        if (exp_q.size() == 0) chk("unexpected_valid", bus.out_valid, 0);
        else begin
          cur = exp_q.pop_front(); have = 1;
          glog.push_back(bus.out_src);
          chk("out_addr", bus.out_addr, cur.addr);
          chk("out_uncached", bus.out_uncached, cur.unc);
          chk("out_write", bus.out_write, cur.wr);
          chk("out_strobe", bus.out_strobe, cur.st);
          chk("out_wdata", bus.out_wdata, cur.wd);
          chk("out_src", bus.out_src, cur.src);
          chk("issue_latency", cyc, cur.cyc + 1);
        end
      end else if (have) begin
        chk("hold_addr_wdata", {bus.out_addr, bus.out_wdata}, {cur.addr, cur.wd});
        chk("hold_ctrl", {bus.out_uncached, bus.out_write, bus.out_strobe, bus.out_src}, {cur.unc, cur.wr, cur.st, cur.src});
      end
      if (wait_st) chk("wait_out_valid", bus.out_valid, 0);
      if (dq.size() != 0) begin
        done_t e;
        e = dq.pop_front();
        chk("done_lines", {bus.i_done, bus.d_done}, e.src ? 2'b01 : 2'b10);
        chk("rdata", e.src ? bus.d_rdata : bus.i_rdata, e.rd);
        have = 0; wait_st = 0;
      end else begin
        chk("no_done", {bus.i_done, bus.d_done}, 2'b00);
        if (bus.out_valid && bus.out_ready) wait_st = 1;
      end
      if (exp_q.size() != 0 && cyc - exp_q[0].cyc > 30) begin
        n_cmp++; n_bad++;
        $display("FAIL grant_timeout: request pushed at cycle %0d never issued", exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      pv = bus.out_valid;
    end
  end

  initial begin
    logic [9:0] pat;
    int n;
    bus.i_valid = 0; bus.i_addr = 0; bus.d_valid = 0; bus.d_addr = 0; bus.d_write = 0;
    bus.d_strobe = 0; bus.d_wdata = 0; bus.out_ready = 0; bus.out_done = 0; bus.out_rdata = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_addr_wdata", {bus.out_addr, bus.out_wdata}, 0);
    chk("rst_ctrl", {bus.out_uncached, bus.out_write, bus.out_strobe, bus.out_src}, 0);
    chk("rst_dones", {bus.i_done, bus.d_done}, 0);
    chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    @(negedge clk);
    resetn = 1;
    repeat (60) step(100, 100, 100, 100);
    pat = 10'b1111011110;
    if (glog.size() < 10) chk("grant_count", glog.size(), 10);
    else for (int i = 0; i < 10; i++) chk("grant_order", glog[i], pat[9 - i]);
    repeat (3000) step(30, 40, 60, 40);
    n = 0;
    while (!acc && n < 200) begin step(100, 100, 100, 0); n++; end
    if (!acc) begin n_cmp++; n_bad++; $display("FAIL wait_timeout: never reached accepted state"); end
    hold_reset(1'b1);
    repeat (2000) step(50, 50, 50, 50);
    repeat (60) step(0, 0, 100, 100);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_q_drained", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
